// File: rtl/stream_mux_2_1.sv
// stream_mux_2_1
// Merges two valid/ready byte streams onto one registered output stream.
// Arbitration is round-robin between the two sources. With LOCK_EN=1 the
// grant stays on one source from its first beat to its in_last beat, so
// multi-beat packets are never interleaved. With LOCK_EN=0 the arbiter
// re-arbitrates on every beat.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in0_valid/data/last/ready   source 0 stream
//   in1_valid/data/last/ready   source 1 stream
//   out_valid/data/last         registered output stream
//   out_src                     source index of the current output beat
//   out_ready                   sink accepts the output beat
module stream_mux_2_1 #(
    parameter int DATA_W  = 8,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    output logic              in0_ready,

    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              in1_ready,

    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_src,
    input  logic              out_ready
);

    logic              load;
    logic              lock;
    logic              lock_src;
    logic              prio;
    logic              grant_vld;
    logic              grant_src;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;
    logic              xfer;

    // The output register can take a new beat when it is empty or its
    // current beat is being consumed this cycle.
    assign load = ~out_valid | out_ready;

    // While locked the grant sits on the locked source even if that source
    // has dropped valid: the mux stalls instead of letting the other source
    // break into the packet.
    always_comb begin
        grant_vld = 1'b0;
        grant_src = 1'b0;
        if (lock) begin
            grant_vld = 1'b1;
            grant_src = lock_src;
        end else if (in0_valid & in1_valid) begin
            grant_vld = 1'b1;
            grant_src = prio;
        end else if (in1_valid) begin
            grant_vld = 1'b1;
            grant_src = 1'b1;
        end else if (in0_valid) begin
            grant_vld = 1'b1;
            grant_src = 1'b0;
        end
    end

    assign in0_ready = load & grant_vld & ~grant_src;
    assign in1_ready = load & grant_vld &  grant_src;

    assign sel_valid = grant_src ? in1_valid : in0_valid;
    assign sel_data  = grant_src ? in1_data  : in0_data;
    assign sel_last  = grant_src ? in1_last  : in0_last;
    assign xfer      = load & grant_vld & sel_valid;

    // Output register: data/last/src only move on a transfer, so an empty
    // load cycle just clears out_valid and leaves the payload as it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= sel_data;
                out_last <= sel_last;
                out_src  <= grant_src;
            end
        end
    end

    // Arbitration state. prio points at the source that wins the next tie;
    // it only flips at a packet end when locking, so a packet's own beats
    // never disturb the round-robin order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock     <= 1'b0;
            lock_src <= 1'b0;
            prio     <= 1'b0;
        end else if (xfer) begin
            if (sel_last) begin
                lock <= 1'b0;
                prio <= ~grant_src;
            end else if (LOCK_EN) begin
                lock     <= 1'b1;
                lock_src <= grant_src;
            end else begin
                prio <= ~grant_src;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_2_1.sv
module tb_stream_mux_2_1;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
        logic         src;
    } obeat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // index [d][k]: d = DUT (0: LOCK_EN=1, 1: LOCK_EN=0), k = source
    logic         v    [2][2];
    logic [W-1:0] dat  [2][2];
    logic         lst  [2][2];
    logic         rdy  [2][2];
    logic         ov   [2];
    logic [W-1:0] od   [2];
    logic         ol   [2];
    logic         os   [2];
    logic         ordy [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        stream_mux_2_1 #(.DATA_W(W), .LOCK_EN(g == 0)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in0_valid (v[g][0]),
            .in0_data  (dat[g][0]),
            .in0_last  (lst[g][0]),
            .in0_ready (rdy[g][0]),
            .in1_valid (v[g][1]),
            .in1_data  (dat[g][1]),
            .in1_last  (lst[g][1]),
            .in1_ready (rdy[g][1]),
            .out_valid (ov[g]),
            .out_data  (od[g]),
            .out_last  (ol[g]),
            .out_src   (os[g]),
            .out_ready (ordy[g])
        );
    end

    // stimulus state
    beat_t  src_q [2][2][$];
    beat_t  cur_b [2][2];
    bit     cur_v [2][2];

    // reference model: arbitration state and expected output beats
    bit     m_lock [2];
    bit     m_lsrc [2];
    bit     m_prio [2];
    bit     m_ov   [2];
    obeat_t sb     [2][$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int d,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_lock[d] = 1'b0;
            m_lsrc[d] = 1'b0;
            m_prio[d] = 1'b0;
            m_ov[d]   = 1'b0;
            sb[d].delete();
        end
    endtask

    task automatic drive_inputs(input int gap, input int rdy_pct, input bit stall);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                if (!cur_v[d][k] && src_q[d][k].size() != 0 &&
                    int'($urandom_range(99)) >= gap) begin
                    cur_b[d][k] = src_q[d][k].pop_front();
                    cur_v[d][k] = 1'b1;
                end
                v[d][k]   = cur_v[d][k];
                dat[d][k] = cur_v[d][k] ? cur_b[d][k].data : W'($urandom);
                lst[d][k] = cur_v[d][k] ? cur_b[d][k].last : 1'($urandom_range(1));
            end
            ordy[d] = !stall && (int'($urandom_range(99)) < rdy_pct);
        end
    endtask

    // Called #1 after the inputs change: predicts the grant from the
    // round-robin / packet-lock rules, checks the readies and queues the
    // beat that must appear on the output.
    task automatic model_step(input bit first_after_rst);
        for (int d = 0; d < 2; d++) begin
            bit load;
            bit gv;
            bit xf;
            int gs;
            check("out_valid", d, 32'(ov[d]), 32'(m_ov[d]));
            load = !m_ov[d] || ordy[d];
            gv = 1'b0;
            gs = 0;
            if (m_lock[d]) begin
                gv = 1'b1;
                gs = int'(m_lsrc[d]);
            end else if (v[d][0] && v[d][1]) begin
                gv = 1'b1;
                gs = int'(m_prio[d]);
            end else if (v[d][1]) begin
                gv = 1'b1;
                gs = 1;
            end else if (v[d][0]) begin
                gv = 1'b1;
                gs = 0;
            end
            for (int k = 0; k < 2; k++)
                check("in_ready", d, 32'(rdy[d][k]), 32'(load && gv && gs == k));
            if (first_after_rst)
                check("grant_after_reset", d, 32'(rdy[d][0]), 32'(1));
            xf = load && gv && v[d][gs];
            if (xf) begin
                sb[d].push_back('{data: dat[d][gs], last: lst[d][gs], src: gs[0]});
                if (lst[d][gs]) begin
                    m_lock[d] = 1'b0;
                    m_prio[d] = ~gs[0];
                end else if (d == 0) begin
                    m_lock[d] = 1'b1;
                    m_lsrc[d] = gs[0];
                end else begin
                    m_prio[d] = ~gs[0];
                end
            end
            if (load) m_ov[d] = xf;
            for (int k = 0; k < 2; k++)
                if (v[d][k] && rdy[d][k]) cur_v[d][k] = 1'b0;
        end
    endtask

    function automatic bit all_idle();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++)
                if (src_q[d][k].size() != 0 || cur_v[d][k]) return 1'b0;
            if (sb[d].size() != 0 || m_ov[d]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic run_phase(input int gap, input int rdy_pct,
                             input int st_from, input int st_to, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(negedge clk);
            drive_inputs(gap, rdy_pct, c >= st_from && c < st_to);
            #1;
            model_step(1'b0);
            done = all_idle();
        end
        check("phase_drained", 0, 32'(done), 32'(1));
    endtask

    task automatic push_both(input int k, input logic [W-1:0] data, input logic last);
        for (int d = 0; d < 2; d++) src_q[d][k].push_back('{data: data, last: last});
    endtask

    // Output monitor: pops the scoreboard on every output handshake and
    // checks that a stalled beat is held unchanged.
    initial begin
        bit     pstall [2];
        obeat_t pval   [2];
        obeat_t e;
        pstall = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                pstall = '{1'b0, 1'b0};
            end else begin
                for (int d = 0; d < 2; d++) begin
                    if (pstall[d]) begin
                        check("stall_valid", d, 32'(ov[d]), 32'(1));
                        check("stall_hold", d, 32'({od[d], ol[d], os[d]}), 32'(pval[d]));
                    end
                    if (ov[d] && ordy[d]) begin
                        if (sb[d].size() == 0) begin
                            check("beat_expected", d, 32'(sb[d].size()), 32'(1));
                        end else begin
                            e = sb[d].pop_front();
                            check("out_beat", d, 32'({od[d], ol[d], os[d]}), 32'(e));
                        end
                    end
                    pstall[d] = ov[d] && !ordy[d];
                    pval[d]   = '{data: od[d], last: ol[d], src: os[d]};
                end
            end
        end
    end

    // Sources must hold valid and data until the beat is accepted.
    logic         pend  [2][2];
    logic [W-1:0] pdat  [2][2];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                if (rst_n && pend[d][k])
                    assert (v[d][k] && dat[d][k] == pdat[d][k])
                    else $error("input stability rule broken dut%0d src%0d", d, k);
                pend[d][k] <= rst_n && v[d][k] && !rdy[d][k];
                pdat[d][k] <= dat[d][k];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            ordy[d] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                cur_v[d][k] = 1'b0;
                v[d][k]     = 1'b0;
                dat[d][k]   = '0;
                lst[d][k]   = 1'b0;
            end
        end
        model_reset();

        repeat (2) @(negedge clk);
        #3;
        for (int d = 0; d < 2; d++) begin
            check("reset_valid", d, 32'(ov[d]), 32'(0));
            check("reset_data",  d, 32'(od[d]), 32'(0));
            check("reset_last",  d, 32'(ol[d]), 32'(0));
            check("reset_src",   d, 32'(os[d]), 32'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // single beat from source 0
        push_both(0, 8'hA1, 1'b1);
        run_phase(0, 100, 0, 0, 50);

        // both sources with single-beat packets: strict alternation
        for (int i = 0; i < 4; i++) begin
            push_both(0, 8'h10, 1'b1);
            push_both(1, 8'h20, 1'b1);
        end
        run_phase(0, 100, 0, 0, 50);

        // 3-beat packet on source 1 against a continuously valid source 0
        push_both(1, 8'h31, 1'b0);
        push_both(1, 8'h32, 1'b0);
        push_both(1, 8'h33, 1'b1);
        for (int i = 0; i < 6; i++) push_both(0, 8'h01, 1'b1);
        run_phase(0, 100, 0, 0, 50);

        // four cycles of backpressure on a held beat
        push_both(0, 8'h55, 1'b1);
        push_both(0, 8'h56, 1'b1);
        push_both(1, 8'h66, 1'b1);
        run_phase(0, 100, 1, 5, 50);

        // random packets, random gaps, random backpressure
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 25; p++) begin
                int len;
                len = int'($urandom_range(4, 1));
                for (int b = 0; b < len; b++)
                    push_both(k, W'($urandom), b == len - 1);
            end
        end
        run_phase(30, 70, 0, 0, 3000);

        // reset in the middle of a locked packet
        push_both(1, 8'h31, 1'b0);
        push_both(1, 8'h32, 1'b0);
        push_both(1, 8'h33, 1'b1);
        for (int c = 0; c < 50 && !m_lock[0]; c++) begin
            @(negedge clk);
            drive_inputs(0, 100, 1'b0);
            #1;
            model_step(1'b0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) check("async_reset_valid", d, 32'(ov[d]), 32'(0));
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) push_both(0, 8'h01, 1'b1);
        @(negedge clk);
        drive_inputs(0, 100, 1'b0);
        rst_n = 1'b1;
        #1;
        model_step(1'b1);
        run_phase(0, 100, 0, 0, 100);

        for (int d = 0; d < 2; d++) check("scoreboard_empty", d, 32'(sb[d].size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
